tgmux_sel_ctrl: RTL and testbench
=================================

# tgmux_sel_ctrl

Sequential select controller that drives the four gate controls (CKN1/CKP1, CKN2/CKP2) of the double transmission-gate mux RC model. It converts a requested path (D1 or D2) into complementary, break-before-make gate signals, so the two transmission gates never conduct together and the shared output node never shorts D1 to D2. Outputs are xbit. They feed the mux through the standard xbit-to-xreal drivers referenced to VDD.

## Interface

Parameters:
- DEAD_CYC, default 2: dead time in clk cycles with both gates off between paths. Legal range 1 .. 2^CNT_W-1.
- CNT_W, default 4: dead-time counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  1 = a path may conduct; 0 = both gates forced off.
- sel_req  in  1  requested path: 0 = D1, 1 = D2.
- ckn1  out  1  nmos gate, path 1 (1 = on).
- ckp1  out  1  pmos gate, path 1 (0 = on); always equal to ~ckn1.
- ckn2  out  1  nmos gate, path 2.
- ckp2  out  1  pmos gate, path 2; always equal to ~ckn2.
- sel_cur  out  1  path currently or last conducting.
- busy  out  1  1 while in DEAD state.
- sw_done  out  1  one-cycle pulse on the cycle a path turns on.

## Operation

- State machine states: OFF, DEAD, ON1, ON2. Registers: `tgt` (target path) and `cnt` (CNT_W bits).
- Reset, asynchronous: state = OFF, cnt = 0, tgt = 0.
  - Outputs at reset: ckn1 = ckn2 = 0, ckp1 = ckp2 = 1, sel_cur = 0, busy = 0, sw_done = 0.
- All outputs are registered and decoded from the next state, so no glitches reach the gates. ckpX is the exact complement of cknX in every cycle.
- OFF state:
  - If en = 1: go to DEAD, tgt <= sel_req, cnt <= DEAD_CYC-1.
  - Otherwise stay in OFF.
- DEAD state (both paths off, busy = 1):
  - If en = 0: go to OFF.
  - Otherwise tgt <= sel_req every cycle, so the latest request wins. The counter is not restarted by a request change.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt = 0: go to ON1 if tgt resolves to 0, else ON2. The target used is the sel_req sampled on that same edge.
  - On entering ON: sw_done = 1 for one cycle; sel_cur <= the target.
- ON1 / ON2 states:
  - Only the matching path is on (ckn = 1, ckp = 0).
  - If en = 0: go to OFF; sel_cur holds.
  - If sel_req differs from the current path: go to DEAD, cnt <= DEAD_CYC-1, tgt <= sel_req.
  - Otherwise hold.
- Simultaneous en = 0 and a sel_req change: en = 0 has priority; go to OFF.
- Invariant, checked every cycle: ckn1 & ckn2 == 0. Any transition between ON1 and ON2 passes through at least DEAD_CYC cycles of DEAD.
- sel_cur changes only on entry to ON1 or ON2.

## Timing

- Path change latency:
  - sel_req toggles while in ONx and is sampled at edge k.
  - Both gates are off from edge k.
  - The new path turns on at edge k+DEAD_CYC.
  - Off interval is exactly DEAD_CYC cycles.
  - sw_done is high for the cycle following edge k+DEAD_CYC.
- Startup: en rises and is sampled at edge k; the first path is on at edge k+DEAD_CYC.
- Disable: en = 0 sampled at edge k; both gates are off after edge k (1-cycle latency).
- Reset mid-operation: all gates turn off immediately (asynchronously), independent of clk. After release, the block restarts from OFF and the full dead time applies before any path turns on.
- busy is high exactly during the DEAD cycles. sw_done never coincides with busy.

## Test plan

- Reset with DEAD_CYC = 2, en = 1, sel_req = 1 held during reset:
  - During reset, outputs are ckn = 00, ckp = 11, sel_cur = 0.
  - After release: 2 DEAD cycles (busy = 1), then ckn2 = 1, ckp2 = 0, sel_cur = 1, sw_done pulses once.
- Steady in ON1, toggle sel_req to 1 at edge k:
  - ckn1 = 0 from edge k; ckn1 = ckn2 = 0 for 2 cycles.
  - ckn2 = 1 from edge k+2; sw_done high one cycle.
- While in DEAD, toggle sel_req 1 -> 0 -> 1:
  - Counter is not restarted; the final path is ON2 at the original time.
  - ckn1 never rises.
- en = 0 while in ON2:
  - All gates off the next cycle; sel_cur stays 1; no sw_done.
- Assert rst asynchronously mid-DEAD and mid-ON1:
  - Outputs reset before the next clk edge.
  - Recovery repeats the full DEAD_CYC interval.
- DEAD_CYC = 15, random en/sel_req for 10k cycles:
  - ckn1 & ckn2 is never 1.
  - ckp equals ~ckn on every cycle.
  - Every ON1 <-> ON2 change is separated by at least 15 all-off cycles.

Source files
------------

// File: rtl/tgmux_sel_ctrl.sv
// Break-before-make select controller for a double transmission-gate mux.
// Converts a requested path into complementary gate controls and keeps both
// gates off for a fixed dead time whenever the conducting path changes.
module tgmux_sel_ctrl #(
  parameter int unsigned DEAD_CYC = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel_req,
  output logic ckn1,
  output logic ckp1,
  output logic ckn2,
  output logic ckp2,
  output logic sel_cur,
  output logic busy,
  output logic sw_done
);

  typedef enum logic [1:0] {StOff, StDead, StOn1, StOn2} state_e;

  // Loading DEAD_CYC-1 and turning on when the count reaches zero gives
  // exactly DEAD_CYC cycles with both gates off.
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DEAD_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             ckn1_q, ckn1_d;
  logic             ckn2_q, ckn2_d;
  logic             ckp1_q, ckp2_q;
  logic             sel_cur_q, sel_cur_d;
  logic             busy_q, busy_d;
  logic             sw_done_q, sw_done_d;
  logic             on_path;

  // Next-state logic; en = 0 overrides every other condition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    sel_cur_d = sel_cur_q;
    sw_done_d = 1'b0;
    on_path   = (state_q == StOn2);
    unique case (state_q)
      StOff: begin
        if (en) begin
          state_d = StDead;
          tgt_d   = sel_req;
          cnt_d   = CntLoad;
        end
      end
      StDead: begin
        if (!en) begin
          state_d = StOff;
        end else begin
          // Latest request wins; the dead-time count is never restarted here.
          tgt_d = sel_req;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d   = sel_req ? StOn2 : StOn1;
            sel_cur_d = sel_req;
            sw_done_d = 1'b1;
          end
        end
      end
      StOn1, StOn2: begin
        if (!en) begin
          state_d = StOff;
        end else if (sel_req != on_path) begin
          state_d = StDead;
          tgt_d   = sel_req;
          cnt_d   = CntLoad;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Gate controls decoded from the next state so the registered outputs are glitch-free.
  always_comb begin
    ckn1_d = (state_d == StOn1);
    ckn2_d = (state_d == StOn2);
    busy_d = (state_d == StDead);
  end

  // State and registered outputs; reset forces both gates off immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      tgt_q     <= 1'b0;
      ckn1_q    <= 1'b0;
      ckn2_q    <= 1'b0;
      ckp1_q    <= 1'b1;
      ckp2_q    <= 1'b1;
      sel_cur_q <= 1'b0;
      busy_q    <= 1'b0;
      sw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      ckn1_q    <= ckn1_d;
      ckn2_q    <= ckn2_d;
      ckp1_q    <= ~ckn1_d;
      ckp2_q    <= ~ckn2_d;
      sel_cur_q <= sel_cur_d;
      busy_q    <= busy_d;
      sw_done_q <= sw_done_d;
    end
  end

  assign ckn1    = ckn1_q;
  assign ckp1    = ckp1_q;
  assign ckn2    = ckn2_q;
  assign ckp2    = ckp2_q;
  assign sel_cur = sel_cur_q;
  assign busy    = busy_q;
  assign sw_done = sw_done_q;

endmodule

// File: tb/tb_tgmux_sel_ctrl.sv
// Scoreboard bench for tgmux_sel_ctrl: two instances (dead time 2 and 15)
// share stimulus; a reference model queues expected outputs per cycle and a
// monitor pops and compares them, plus per-cycle safety invariants.
module tb_tgmux_sel_ctrl;

  localparam int DC0 = 2;
  localparam int DC1 = 15;
  localparam logic [6:0] RstVec = 7'b0101000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sel_req = 1'b0;

  logic ckn1_w [2];
  logic ckp1_w [2];
  logic ckn2_w [2];
  logic ckp2_w [2];
  logic sel_cur_w [2];
  logic busy_w [2];
  logic sw_done_w [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tgmux_sel_ctrl #(.DEAD_CYC(DC0), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .sel_req(sel_req),
    .ckn1(ckn1_w[0]), .ckp1(ckp1_w[0]), .ckn2(ckn2_w[0]), .ckp2(ckp2_w[0]),
    .sel_cur(sel_cur_w[0]), .busy(busy_w[0]), .sw_done(sw_done_w[0])
  );

  tgmux_sel_ctrl #(.DEAD_CYC(DC1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .sel_req(sel_req),
    .ckn1(ckn1_w[1]), .ckp1(ckp1_w[1]), .ckn2(ckn2_w[1]), .ckp2(ckp2_w[1]),
    .sel_cur(sel_cur_w[1]), .busy(busy_w[1]), .sw_done(sw_done_w[1])
  );

  function automatic logic [6:0] obs(int i);
    return {ckn1_w[i], ckp1_w[i], ckn2_w[i], ckp2_w[i], sel_cur_w[i], busy_w[i], sw_done_w[i]};
  endfunction

  // Reference model: which path conducts (0 none, 1 = D1, 2 = D2), whether we
  // are in the dead interval and how many dead cycles have elapsed so far.
  int m_on [2];
  bit m_dead [2];
  int m_el [2];
  bit m_cur [2];
  logic [6:0] exp_a [$];
  logic [6:0] exp_b [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_dead[i] = 1'b0; m_el[i] = 0; m_cur[i] = 1'b0;
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic model_step(input int i, input bit e, input bit s, output logic [6:0] v);
    int dcv;
    bit sw;
    dcv = (i == 0) ? DC0 : DC1;
    sw = 1'b0;
    if (!e) begin
      m_on[i] = 0;
      m_dead[i] = 1'b0;
    end else if (m_dead[i]) begin
      if (m_el[i] == dcv) begin
        m_dead[i] = 1'b0;
        m_on[i] = s ? 2 : 1;
        m_cur[i] = s;
        sw = 1'b1;
      end else begin
        m_el[i]++;
      end
    end else if (m_on[i] == 0 || s != (m_on[i] == 2)) begin
      m_on[i] = 0;
      m_dead[i] = 1'b1;
      m_el[i] = 1;
    end
    v = {m_on[i] == 1, m_on[i] != 1, m_on[i] == 2, m_on[i] != 2, m_cur[i], m_dead[i], sw};
  endtask

  // Drive one cycle of stimulus at the falling edge and queue expectations.
  task automatic drive(input bit e, input bit s, input bit release_rst);
    logic [6:0] va, vb;
    @(negedge clk);
    if (release_rst) begin
      rst = 1'b0;
      model_reset();
    end
    en = e;
    sel_req = s;
    model_step(0, e, s, va);
    model_step(1, e, s, vb);
    exp_a.push_back(va);
    exp_b.push_back(vb);
  endtask

  task automatic check_rst_vec(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== RstVec) begin
        errors++;
        $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", name, i, cyc, obs(i), RstVec);
      end
    end
  endtask

  // Assert reset between clock edges; outputs must clear without a clock.
  task automatic async_rst(input string name);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_rst_vec(name);
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare queued expectations and check gate-safety invariants.
  int last_path [2] = '{0, 0};
  int off_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    logic [6:0] e, o;
    int dcv;
    #1;
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      dcv = (i == 0) ? DC0 : DC1;
      if ((i == 0 && exp_a.size() > 0) || (i == 1 && exp_b.size() > 0)) begin
        e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL outputs dut%0d cyc=%0d got=%b exp=%b", i, cyc, o, e);
        end
      end
      checks++;
      if ((ckn1_w[i] & ckn2_w[i]) !== 1'b0 || ckp1_w[i] !== ~ckn1_w[i]
          || ckp2_w[i] !== ~ckn2_w[i] || (busy_w[i] & sw_done_w[i]) !== 1'b0) begin
        errors++;
        $display("FAIL gate_invariant dut%0d cyc=%0d got=%b exp=no_overlap_complementary", i, cyc, o);
      end
      if (ckn1_w[i] || ckn2_w[i]) begin
        if (last_path[i] != 0 && last_path[i] != (ckn1_w[i] ? 1 : 2)) begin
          checks++;
          if (off_cnt[i] < dcv) begin
            errors++;
            $display("FAIL dead_interval dut%0d cyc=%0d got=%0d exp>=%0d", i, cyc, off_cnt[i], dcv);
          end
        end
        last_path[i] = ckn1_w[i] ? 1 : 2;
        off_cnt[i] = 0;
      end else begin
        off_cnt[i]++;
      end
    end
  end

  initial begin
    bit s;
    model_reset();
    // Held reset with en = 1, sel_req = 1.
    rst = 1'b1; en = 1'b1; sel_req = 1'b1;
    repeat (3) @(negedge clk);
    check_rst_vec("reset_hold");
    drive(1, 1, 1);
    repeat (20) drive(1, 1, 0);
    // Steady D1, then request D2.
    repeat (20) drive(1, 0, 0);
    repeat (20) drive(1, 1, 0);
    repeat (20) drive(1, 0, 0);
    // Request changes during the dead interval.
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    repeat (20) drive(1, 1, 0);
    // Disable while on D2, then simultaneous disable and request change.
    repeat (3) drive(0, 1, 0);
    repeat (20) drive(1, 1, 0);
    drive(0, 0, 0);
    repeat (2) drive(0, 0, 0);
    // Reset mid-dead and mid-on.
    repeat (20) drive(1, 0, 0);
    drive(1, 1, 0);
    async_rst("reset_mid_dead");
    drive(1, 0, 1);
    repeat (25) drive(1, 0, 0);
    async_rst("reset_mid_on1");
    drive(1, 0, 1);
    repeat (25) drive(1, 0, 0);
    // Randomized traffic.
    s = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 39) == 0) s = ~s;
      drive(($urandom_range(0, 199) != 0), s, 0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d exp=0/0", exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
